// File: rtl/phantom_clock_gate.sv
// phantom_clock_gate: phantom real-time clock inserted in the RAM/ROM chip-select path.
// A 64-bit write pattern on D0 unlocks a 64-access serial transfer of the BCD time.
// During the transfer, chip select to the card RAM/ROM is suppressed. Otherwise chip
// select passes through and the time advances on a C7M-derived 100 Hz tick.
//
// Access handshake: nCEI is treated as an asynchronous strobe. It is resynchronised
// through two flops. An access event fires on the third C7M edge after nCEI falls,
// and a release event fires on the third edge after it rises. nWE and DIN0 must be
// stable on the event edge and are sampled only there.
`timescale 1ns/1ps

module phantom_clock_gate #(
  parameter int unsigned TICK_DIV = 71591,
  parameter logic [63:0] PATTERN  = 64'h5CA33AC55CA33AC5
) (
  input  logic C7M,
  input  logic RES,
  input  logic nCEI,
  input  logic nWE,
  input  logic DIN0,
  output logic DOUT0,
  output logic DOE,
  output logic CSGB,
  output logic DAYROLL
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MATCH = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t        state;
  logic [5:0]    idx;
  logic [63:0]   sr;
  logic          allwr;

  logic          ncei_s1;
  logic          ncei_s2;
  logic          ncei_q;
  logic          acc_evt;
  logic          rel_evt;

  logic [PW-1:0] pre;
  logic          tick;
  logic          load;

  logic [7:0]    hund;
  logic [7:0]    sec;
  logic [7:0]    min;
  logic [7:0]    hour;
  logic [2:0]    day;
  logic [7:0]    date;
  logic [7:0]    month;
  logic [7:0]    year;
  logic [63:0]   live_time;

  // Per-digit BCD increment; each nibble wraps modulo 10 so bad loaded digits self-heal.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = v[3:0];
    hi = v[7:4];
    if (lo >= 4'd9) begin
      lo = 4'd0;
      hi = (hi >= 4'd9) ? 4'd0 : hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

  assign acc_evt   = ncei_q & ~ncei_s2;
  assign rel_evt   = ~ncei_q & ncei_s2;
  assign tick      = (pre == PW'(TICK_DIV - 1));
  assign load      = (state == DONE) && rel_evt && allwr;
  assign live_time = {year, month, date, 5'b00000, day, hour, min, sec, hund};

  // Chip-select gating is combinational from the registered state so pass-through adds no delay.
  assign CSGB = !nCEI && !((state == XFER) || (state == DONE));
  assign DOE  = !nCEI && nWE && ((state == XFER) || (state == DONE));

  // Two-flop synchroniser plus one history flop for edge detection on nCEI.
  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      ncei_s1 <= 1'b1;
      ncei_s2 <= 1'b1;
      ncei_q  <= 1'b1;
    end else begin
      ncei_s1 <= nCEI;
      ncei_s2 <= ncei_s1;
      ncei_q  <= ncei_s2;
    end
  end

  // Free-running 100 Hz prescaler.
  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // Live time: a software load beats a coincident tick (that tick is dropped).
  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      hund    <= 8'h00;
      sec     <= 8'h00;
      min     <= 8'h00;
      hour    <= 8'h00;
      day     <= 3'd1;
      date    <= 8'h00;
      month   <= 8'h00;
      year    <= 8'h00;
      DAYROLL <= 1'b0;
    end else begin
      DAYROLL <= 1'b0;
      if (load) begin
        hund  <= sr[7:0];
        sec   <= sr[15:8];
        min   <= sr[23:16];
        hour  <= sr[31:24];
        day   <= sr[34:32];
        date  <= sr[47:40];
        month <= sr[55:48];
        year  <= sr[63:56];
      end else if (tick) begin
        if (hund == 8'h99) begin
          hund <= 8'h00;
          if (sec == 8'h59) begin
            sec <= 8'h00;
            if (min == 8'h59) begin
              min <= 8'h00;
              if (hour == 8'h23) begin
                hour    <= 8'h00;
                day     <= (day == 3'd7) ? 3'd1 : day + 3'd1;
                DAYROLL <= 1'b1;
              end else begin
                hour <= bcd_inc(hour);
              end
            end else begin
              min <= bcd_inc(min);
            end
          end else begin
            sec <= bcd_inc(sec);
          end
        end else begin
          hund <= bcd_inc(hund);
        end
      end
    end
  end

  // Unlock matcher and serial transfer FSM.
  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      state <= IDLE;
      idx   <= 6'd0;
      sr    <= 64'd0;
      allwr <= 1'b0;
      DOUT0 <= 1'b0;
    end else begin
      case (state)
        IDLE, MATCH: begin
          if (acc_evt) begin
            if (!nWE) begin
              if (DIN0 == PATTERN[idx]) begin
                if (idx == 6'd63) begin
                  state <= XFER;
                  idx   <= 6'd0;
                  sr    <= live_time;
                  allwr <= 1'b1;
                end else begin
                  state <= MATCH;
                  idx   <= idx + 6'd1;
                end
              end else if (DIN0 == PATTERN[0]) begin
                // The breaking bit may itself start a fresh match.
                state <= MATCH;
                idx   <= 6'd1;
              end else begin
                state <= IDLE;
                idx   <= 6'd0;
              end
            end else begin
              state <= IDLE;
              idx   <= 6'd0;
            end
          end
        end
        XFER: begin
          if (acc_evt) begin
            if (nWE) begin
              DOUT0 <= sr[idx];
              allwr <= 1'b0;
            end else begin
              sr[idx] <= DIN0;
            end
            idx <= idx + 6'd1;
            if (idx == 6'd63) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (rel_evt) begin
            state <= IDLE;
            idx   <= 6'd0;
          end
        end
        default: begin
          state <= IDLE;
          idx   <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phantom_clock_gate.sv
// tb_phantom_clock_gate: randomized bench for phantom_clock_gate against a behavioural model.
// Two instances share the bus: dut_m (default divider) and dut_f (TICK_DIV=4) for the rollover test.
`timescale 1ns/1ps

module tb_phantom_clock_gate;

  localparam logic [63:0] PAT       = 64'h5CA33AC55CA33AC5;
  localparam logic [63:0] TIME_MASK = 64'hFFFF_FF07_FFFF_FFFF;

  logic C7M = 1'b0;
  logic rst_m, rst_f;
  logic nCEI, nWE, DIN0;
  logic dout_m, doe_m, csgb_m, roll_m;
  logic dout_f, doe_f, csgb_f, roll_f;

  // Clock and cycle counter.
  always #5 C7M = ~C7M;
  int unsigned cyc = 0;
  always @(posedge C7M) cyc <= cyc + 1;

  phantom_clock_gate dut_m (
    .C7M(C7M), .RES(rst_m), .nCEI(nCEI), .nWE(nWE), .DIN0(DIN0),
    .DOUT0(dout_m), .DOE(doe_m), .CSGB(csgb_m), .DAYROLL(roll_m)
  );

  phantom_clock_gate #(.TICK_DIV(4)) dut_f (
    .C7M(C7M), .RES(rst_f), .nCEI(nCEI), .nWE(nWE), .DIN0(DIN0),
    .DOUT0(dout_f), .DOE(doe_f), .CSGB(csgb_f), .DAYROLL(roll_f)
  );

  // Scoreboard state.
  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];

  // Behavioural model: match count, mode (0 pass, 1 transfer, 2 done), snapshot, live time.
  logic [63:0] pat = PAT;
  int          m_match;
  int          m_mode;
  int          m_xi;
  logic [63:0] m_sr;
  logic [63:0] m_time;
  bit          m_allwr;
  bit          fast_on = 0;
  int unsigned e_cyc;
  logic [63:0] rd_f;

  // Dayroll monitors.
  int          roll_cnt_m = 0;
  int          roll_cnt_f = 0;
  int unsigned roll_cyc   = 0;
  always @(negedge C7M) begin
    if (roll_m === 1'b1) roll_cnt_m++;
    if (roll_f === 1'b1) begin
      roll_cnt_f++;
      roll_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge C7M);
    #1;
  endtask

  task automatic model_reset();
    m_match = 0;
    m_mode  = 0;
    m_xi    = 0;
    m_sr    = 64'd0;
    m_allwr = 0;
    m_time  = 64'h0000_0001_0000_0000;
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  // One bus access with random strobe timing; checks outputs and advances the model.
  task automatic access(input bit we, input bit d);
    int lo;
    int hi;
    int unsigned c0;
    bit exp_cs;
    bit exp_doe;
    lo = $urandom_range(4, 6);
    hi = $urandom_range(3, 5);
    nWE  = !we;
    DIN0 = d;
    nCEI = 1'b0;
    c0   = cyc;
    step(1);
    exp_cs  = (m_mode == 0);
    exp_doe = (m_mode != 0) && !we;
    check("csgb_low", csgb_m, exp_cs);
    check("doe_low", doe_m, exp_doe);
    if (fast_on) begin
      check("csgb_f", csgb_f, exp_cs);
      check("doe_f", doe_f, exp_doe);
    end
    step(2);
    if (m_mode == 0) begin
      if (we) begin
        if (d == pat[m_match]) m_match++;
        else m_match = (d == pat[0]) ? 1 : 0;
        if (m_match == 64) begin
          m_mode  = 1;
          m_match = 0;
          m_xi    = 0;
          m_sr    = m_time;
          m_allwr = 1;
          e_cyc   = c0 + 3;
        end
      end else begin
        m_match = 0;
      end
    end else if (m_mode == 1) begin
      if (!we) begin
        exp_q.push_back(m_sr[m_xi]);
        check("dout", dout_m, exp_q.pop_front());
        if (fast_on) rd_f[m_xi] = dout_f;
        m_allwr = 0;
      end else begin
        m_sr[m_xi] = d;
      end
      m_xi++;
      if (m_xi == 64) m_mode = 2;
    end
    step(lo - 3);
    nCEI = 1'b1;
    nWE  = 1'b1;
    step(hi);
    if (m_mode == 2) begin
      m_mode = 0;
      if (m_allwr) m_time = m_sr & TIME_MASK;
    end
    check("csgb_high", csgb_m, 1'b0);
    check("doe_high", doe_m, 1'b0);
  endtask

  task automatic send_bits(input logic [63:0] v, input int from, input int to);
    for (int i = from; i <= to; i++) access(1'b1, v[i]);
  endtask

  task automatic xfer_write(input logic [63:0] v);
    for (int i = 0; i < 64; i++) access(1'b1, v[i]);
  endtask

  task automatic xfer_read();
    for (int i = 0; i < 64; i++) access(1'b0, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    logic [63:0] exp_f;
    int unsigned n;

    nCEI = 1'b1; nWE = 1'b1; DIN0 = 1'b0;
    rst_m = 1'b1; rst_f = 1'b1;
    model_reset();
    step(3);

    // Reset state.
    check("rst_csgb_idle", csgb_m, 1'b0);
    check("rst_doe", doe_m, 1'b0);
    check("rst_dout", dout_m, 1'b0);
    check("rst_dayroll", roll_m, 1'b0);
    nCEI = 1'b0;
    #1;
    check("rst_csgb_pass", csgb_m, 1'b1);
    check("rst_doe_low", doe_m, 1'b0);
    nCEI = 1'b1;
    step(1);
    rst_m = 1'b0;
    step(4);

    // Plain reads and random writes pass through.
    for (int i = 0; i < 8; i++) access(1'b0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 30; i++) access(1'b1, 1'($urandom_range(0, 1)));
    access(1'b0, 1'b0);

    // Corrupted pattern, then full pattern unlocks; read back the reset time.
    send_bits(PAT ^ (64'h1 << 10), 0, 63);
    access(1'b0, 1'b0);
    send_bits(PAT, 0, 63);
    check("unlock_full", 64'(m_mode), 64'd1);
    xfer_read();

    // Broken by a read mid-pattern, then a full pattern and a random time load.
    send_bits(PAT, 0, 19);
    access(1'b0, 1'b0);
    send_bits(PAT, 20, 63);
    check("no_unlock_split", 64'(m_mode), 64'd0);
    access(1'b0, 1'b0);
    send_bits(PAT, 0, 63);
    v = {$urandom, $urandom};
    xfer_write(v);
    send_bits(PAT, 0, 63);
    xfer_read();

    // 63 writes and one read: time must not change.
    v = m_time;
    send_bits(PAT, 0, 63);
    for (int i = 0; i < 63; i++) access(1'b1, 1'($urandom_range(0, 1)));
    access(1'b0, 1'b0);
    check("time_kept", m_time, v);
    send_bits(PAT, 0, 63);
    xfer_read();

    // Random mixed transfers, each followed by a read-back.
    for (int r = 0; r < 3; r++) begin
      send_bits(PAT, 0, 63);
      for (int i = 0; i < 64; i++) access(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      send_bits(PAT, 0, 63);
      xfer_read();
    end

    // Reset in the middle of a transfer.
    send_bits(PAT, 0, 63);
    for (int i = 0; i < 30; i++) access(1'b1, 1'($urandom_range(0, 1)));
    nWE  = 1'b1;
    nCEI = 1'b0;
    step(1);
    check("pre_rst_csgb", csgb_m, 1'b0);
    rst_m = 1'b1;
    step(1);
    check("mid_rst_csgb", csgb_m, 1'b1);
    check("mid_rst_doe", doe_m, 1'b0);
    nCEI = 1'b1;
    step(3);
    rst_m = 1'b0;
    step(4);
    model_reset();
    send_bits(PAT, 0, 63);
    xfer_read();

    // Day rollover on the fast-tick instance.
    fast_on = 1;
    rst_f = 1'b0;
    step(4);
    access(1'b0, 1'b0);
    roll_cnt_f = 0;
    send_bits(PAT, 0, 63);
    xfer_write(64'h0000_0007_2359_5999);
    step(12);
    check("dayroll_pulses", 64'(roll_cnt_f), 64'd1);
    step(8);
    check("dayroll_width", 64'(roll_cnt_f), 64'd1);
    send_bits(PAT, 0, 63);
    xfer_read();
    n = (e_cyc - 1 - roll_cyc) / 4;
    exp_f = {8'h00, 8'h00, 8'h00, 5'b00000, 3'd1, 8'h00,
             to_bcd(int'((n / 6000) % 60)), to_bcd(int'((n / 100) % 60)), to_bcd(int'(n % 100))};
    check("rollover_time", rd_f, exp_f);
    check("main_no_dayroll", 64'(roll_cnt_m), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
